// File: rtl/fei4_rx_arbiter.sv
// fei4_rx_arbiter: round-robin readout arbiter that merges N first-word-fall-through
// receiver FIFOs into one registered 32-bit valid/ready stream using bounded bursts.
module fei4_rx_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic            BUS_CLK,
  input  logic            BUS_RST_N,
  input  logic [N-1:0]    CH_EN,
  input  logic [N-1:0]    FIFO_EMPTY,
  input  logic [32*N-1:0] FIFO_DATA,
  output logic [N-1:0]    FIFO_READ,
  output logic [31:0]     OUT_DATA,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [N-1:0]    GRANT,
  output logic            BUSY
);

  localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BW  = $clog2(MAX_BURST) + 1;
  localparam logic [PW:0] N_W = (PW+1)'(N);

  typedef enum logic {IDLE, XFER} state_e;

  state_e         state_q;
  logic [PW-1:0]  ptr_q, g_q;
  logic [N-1:0]   grant_q;
  logic [BW-1:0]  burst_q;
  logic [31:0]    out_data_q;
  logic           out_valid_q;

  logic [N-1:0]   req, rot;
  logic [2*N-1:0] req2;
  logic [PW-1:0]  off, sel_d, ptr_d;
  logic [PW:0]    sum;
  logic           slot_free, take, last_d;
  logic [31:0]    ch_data [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = FIFO_DATA[32*i +: 32];
  end

  assign req  = CH_EN & ~FIFO_EMPTY;
  assign req2 = {req, req};

  // Rotate requests so bit 0 is the channel at ptr; the first set bit is the offset from ptr.
  always_comb begin
    rot = N'(req2 >> ptr_q);
    off = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) off = PW'(i-1);
    end
    sum   = {1'b0, ptr_q} + {1'b0, off};
    sel_d = (sum >= N_W) ? PW'(sum - N_W) : sum[PW-1:0];
    ptr_d = (g_q == PW'(N-1)) ? '0 : g_q + 1'b1;
  end

  assign slot_free = !out_valid_q || OUT_READY;
  assign take      = (state_q == XFER) && slot_free && req[g_q];
  assign last_d    = take && (burst_q == BW'(MAX_BURST-1));

  always_comb begin
    FIFO_READ      = '0;
    FIFO_READ[g_q] = take;
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      grant_q     <= '0;
      burst_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (OUT_READY) out_valid_q <= 1'b0;
          if (|req) begin
            g_q     <= sel_d;
            grant_q <= N'(1) << sel_d;
            burst_q <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (take) begin
            out_data_q  <= ch_data[g_q];
            out_valid_q <= 1'b1;
            burst_q     <= burst_q + 1'b1;
          end else if (slot_free) begin
            out_valid_q <= 1'b0;
          end
          // A disabled or drained channel ends the grant on the cycle it is seen.
          if (last_d || !req[g_q]) begin
            state_q <= IDLE;
            ptr_q   <= ptr_d;
            grant_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign GRANT     = grant_q;
  assign BUSY      = (state_q == XFER) || out_valid_q;

endmodule

// File: tb/tb_fei4_rx_arbiter.sv
// Bench for fei4_rx_arbiter: emulated FWFT channel FIFOs, randomized backpressure and a
// transaction-level round-robin model that predicts the grant sequence and the word stream.
module tb_fei4_rx_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned MB  = 16;

  logic              clk = 1'b0;
  logic              BUS_RST_N;
  logic [NCH-1:0]    CH_EN, FIFO_EMPTY, FIFO_READ, GRANT;
  logic [32*NCH-1:0] FIFO_DATA;
  logic [31:0]       OUT_DATA;
  logic              OUT_VALID, OUT_READY, BUSY;

  int unsigned rdp [NCH];
  int unsigned wrp [NCH];
  int unsigned mh  [NCH];
  int unsigned mptr;
  int unsigned n_pass, n_chk;

  logic [31:0] exp_w [$];
  int unsigned exp_gc [$];
  int unsigned exp_gl [$];

  int unsigned    cyc, gap, cur_reads, cur_dur, ngrants, first_cyc;
  logic [NCH-1:0] cur_g;
  bit             in_grant, prev_stall;
  logic [31:0]    prev_data;

  always #5 clk = ~clk;

  fei4_rx_arbiter #(.N(NCH), .MAX_BURST(MB)) dut (
    .BUS_CLK   (clk),
    .BUS_RST_N (BUS_RST_N),
    .CH_EN     (CH_EN),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DATA (FIFO_DATA),
    .FIFO_READ (FIFO_READ),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .GRANT     (GRANT),
    .BUSY      (BUSY)
  );

  function automatic logic [31:0] mkword(input int unsigned c, input int unsigned s);
    return {4'hA, c[3:0], 8'h5A, s[15:0]};
  endfunction

  // Channel FIFOs: word s of channel c is mkword(c, s); loading just advances wrp.
  always_comb begin
    FIFO_EMPTY = '1;
    FIFO_DATA  = '0;
    for (int c = 0; c < NCH; c++) begin
      FIFO_EMPTY[c]         = (rdp[c] >= wrp[c]);
      FIFO_DATA[32*c +: 32] = mkword(c, rdp[c]);
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++)
      if (FIFO_READ[c]) rdp[c] <= rdp[c] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // Round-robin over static contents: from ptr pick the first enabled non-empty channel,
  // take min(MB, remaining) words, move ptr past it, repeat until all enabled are drained.
  task automatic plan();
    int unsigned rem [NCH];
    int unsigned p, c, len;
    bit found;
    exp_w.delete(); exp_gc.delete(); exp_gl.delete();
    for (int k = 0; k < NCH; k++) rem[k] = CH_EN[k] ? (wrp[k] - mh[k]) : 0;
    p = mptr;
    forever begin
      found = 1'b0;
      c = 0;
      for (int k = 0; k < NCH; k++) begin
        if (!found && rem[(p + k) % NCH] > 0) begin
          found = 1'b1;
          c = (p + k) % NCH;
        end
      end
      if (!found) break;
      len = (rem[c] > MB) ? MB : rem[c];
      for (int unsigned j = 0; j < len; j++) begin
        exp_w.push_back(mkword(c, mh[c]));
        mh[c]++;
      end
      rem[c] -= len;
      exp_gc.push_back(c);
      exp_gl.push_back(len);
      p = (c + 1) % NCH;
    end
    mptr = p;
  endtask

  task automatic finalize(input int mode);
    int unsigned c, l;
    if (exp_gc.size() == 0) begin
      chk("extra_grant", 32'(cur_g), 32'd0);
    end else begin
      c = exp_gc.pop_front();
      l = exp_gl.pop_front();
      chk("grant_ch", 32'(cur_g), 32'(1) << c);
      chk("burst_len", cur_reads, l);
      if (mode == 0) chk("grant_dur", cur_dur, (l == MB) ? l : l + 1);
    end
  endtask

  task automatic step(input int mode);
    @(negedge clk);
    case (mode)
      0:       OUT_READY = 1'b1;
      1:       OUT_READY = ($urandom_range(0, 3) != 0);
      default: OUT_READY = !((cyc % 4 == 1) || (cyc % 4 == 2));
    endcase
    #1;
    chk("read_legal", 32'(FIFO_READ & ~(CH_EN & ~FIFO_EMPTY)), 32'd0);
    chk("read_in_grant", 32'(FIFO_READ & ~GRANT), 32'd0);
    chk("busy", 32'(BUSY), 32'((GRANT != '0) || OUT_VALID));
    if (OUT_VALID && !OUT_READY) chk("stall_noread", 32'(FIFO_READ), 32'd0);
    if (prev_stall) begin
      chk("stall_valid", 32'(OUT_VALID), 32'd1);
      chk("stall_data", OUT_DATA, prev_data);
    end
    if (GRANT != '0) begin
      if (!in_grant) begin
        in_grant  = 1'b1;
        cur_g     = GRANT;
        cur_reads = 0;
        cur_dur   = 0;
        if (ngrants > 0) chk("bubble", gap, 1);
        else first_cyc = cyc;
        ngrants++;
      end
      cur_dur++;
      if (FIFO_READ != '0) cur_reads++;
    end else begin
      if (in_grant) begin
        finalize(mode);
        in_grant = 1'b0;
        gap      = 0;
      end
      gap++;
    end
    if (OUT_VALID && OUT_READY) begin
      if (exp_w.size() == 0) chk("extra_word", OUT_DATA, 32'd0);
      else chk("out_data", OUT_DATA, exp_w.pop_front());
    end
    prev_stall = OUT_VALID && !OUT_READY;
    prev_data  = OUT_DATA;
    cyc++;
  endtask

  task automatic run(input int mode, input int unsigned budget);
    bit done;
    plan();
    done = 1'b0; in_grant = 1'b0; ngrants = 0; prev_stall = 1'b0; gap = 0; cyc = 0;
    first_cyc = 32'hFFFF_FFFF;
    for (int unsigned i = 0; i < budget; i++) begin
      step(mode);
      if (exp_w.size() == 0 && exp_gc.size() == 0 && !in_grant && !OUT_VALID) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("run_timeout", 32'd0, 32'd1);
    chk("idle_busy", 32'(BUSY), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    BUS_RST_N = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_grant", 32'(GRANT), 32'd0);
    chk("rst_read", 32'(FIFO_READ), 32'd0);
    BUS_RST_N = 1'b1;
    for (int k = 0; k < NCH; k++) mh[k] = rdp[k];
    mptr = 0;
  endtask

  initial begin
    int unsigned k;
    n_pass = 0; n_chk = 0; mptr = 0;
    for (int c = 0; c < NCH; c++) mh[c] = 0;
    BUS_RST_N = 1'b0;
    OUT_READY = 1'b0;
    CH_EN     = 4'hF;

    // Single channel: 5 words loaded during reset, released, streamed with ready high.
    wrp[0] = 5;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", 32'(OUT_VALID), 32'd0);
    chk("reset_data", OUT_DATA, 32'd0);
    chk("reset_grant", 32'(GRANT), 32'd0);
    chk("reset_read", 32'(FIFO_READ), 32'd0);
    chk("reset_busy", 32'(BUSY), 32'd0);
    @(negedge clk);
    BUS_RST_N = 1'b1;
    run(0, 100);
    chk("first_grant_cyc", first_cyc, 32'd0);

    // Burst limit and fairness from ptr 0: ch0 40 words, ch2 3 words.
    do_reset();
    wrp[0] += 40;
    wrp[2] += 3;
    run(0, 300);

    // Backpressure pattern 1,0,0,1 on a ch1 stream.
    wrp[1] += 20;
    run(2, 300);

    // Enable mask: only ch1 and ch3 may be granted.
    for (int c = 0; c < NCH; c++) wrp[c] += 20;
    CH_EN = 4'b1010;
    run(1, 400);

    // Clear CH_EN[1] during a ch1 burst.
    wrp[1] += 20;
    wrp[3] += 20;
    k = 0;
    for (int i = 0; i < 200 && k < 3; i++) begin
      @(negedge clk);
      OUT_READY = 1'b1;
      #1;
      if (GRANT == 4'b0010 && FIFO_READ[1]) k++;
    end
    chk("dis_wait", k, 32'd3);
    @(negedge clk);
    CH_EN = 4'b1000;
    #1;
    chk("dis_noread", 32'(FIFO_READ), 32'd0);
    chk("dis_grant_held", 32'(GRANT), 32'h2);
    @(negedge clk);
    #1;
    chk("dis_exit", 32'(GRANT), 32'd0);
    @(negedge clk);
    #1;
    chk("dis_next", 32'(GRANT), 32'h8);

    // Resync after a reset and drain everything under random backpressure.
    do_reset();
    CH_EN = 4'hF;
    run(1, 1500);

    // Empty mid-burst on ch3, then ptr must have wrapped to ch0.
    wrp[3] += 2;
    run(0, 100);
    wrp[0] += 1;
    wrp[1] += 1;
    run(0, 100);

    // Reset during a ch0 burst with a word held in the output register.
    wrp[0] += 30;
    k = 0;
    for (int i = 0; i < 100 && k < 3; i++) begin
      @(negedge clk);
      OUT_READY = 1'b1;
      #1;
      if (GRANT == 4'b0001 && OUT_VALID) k++;
    end
    chk("mid_wait", k, 32'd3);
    @(negedge clk);
    BUS_RST_N = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    chk("mid_rst_grant", 32'(GRANT), 32'd0);
    chk("mid_rst_read", 32'(FIFO_READ), 32'd0);
    BUS_RST_N = 1'b1;
    wrp[2] += 5;
    @(negedge clk);
    #1;
    chk("post_rst_grant", 32'(GRANT), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
